// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - RISC-V writeback stage: result select, load align/extend,
// late-load wait with timeout, register-file write, forwarding and retire counter.
module writeback_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64,
  parameter int TMO_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              regwrite_i,
  input  logic [1:0]        WBSel_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   alu_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [XLEN-1:0]   rf_wdata_o,
  output logic              fwd_valid_o,
  output logic              load_err_o,
  output logic [CNT_W-1:0]  instret_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WAIT   = 2'b01,
    S_COMMIT = 2'b10
  } state_t;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Align the addressed lane down to bit 0, then extend by load size/sign.
  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3,
                                                  input logic [1:0] lane,
                                                  input logic [XLEN-1:0] raw);
    logic [XLEN-1:0] sh;
    sh = raw >> {lane, 3'b000};
    case (f3)
      3'b000:  load_extend = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  load_extend = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b100:  load_extend = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  load_extend = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: load_extend = raw;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      3'b000, 3'b100: is_misaligned = 1'b0;
      3'b001, 3'b101: is_misaligned = lane[0];
      default:        is_misaligned = (lane != 2'b00);
    endcase
  endfunction

  state_t              r_state;
  state_t              w_state_next;
  logic [TMO_W-1:0]    r_tmo;
  logic [TMO_W-1:0]    w_tmo_inc;

  logic [REG_AW-1:0]   r_rd;
  logic                r_regwrite;
  logic [2:0]          r_funct3;
  logic [1:0]          r_lane;
  logic                r_misalign;

  logic                r_rf_we;
  logic [REG_AW-1:0]   r_rf_waddr;
  logic [XLEN-1:0]     r_rf_wdata;
  logic                r_load_err;
  logic [CNT_W-1:0]    r_instret;

  logic                w_accept;
  logic                w_in_mem;
  logic                w_commit_new;
  logic                w_commit_wait;
  logic                w_commit;
  logic                w_tmo_fire;
  logic [REG_AW-1:0]   w_src_rd;
  logic                w_src_regwrite;
  logic                w_src_misalign;
  logic [XLEN-1:0]     w_src_wdata;

  assign ready_o   = (r_state == S_IDLE) || (r_state == S_COMMIT);
  assign w_accept  = valid_i && ready_o && !flush_i;
  assign w_in_mem  = (WBSel_i == WB_MEM);
  assign w_tmo_inc = r_tmo + TMO_W'(1);
  assign w_commit  = w_commit_new || w_commit_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_commit_new  = 1'b0;
    w_commit_wait = 1'b0;
    w_tmo_fire    = 1'b0;
    case (r_state)
      S_IDLE, S_COMMIT: begin
        w_state_next = S_IDLE;
        if (w_accept) begin
          if (!w_in_mem || mem_rvalid_i) begin
            w_state_next = S_COMMIT;
            w_commit_new = 1'b1;
          end else begin
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush_i) begin
          w_state_next = S_IDLE;
        end else if (mem_rvalid_i) begin
          w_state_next  = S_COMMIT;
          w_commit_wait = 1'b1;
        end else if (w_tmo_inc == {TMO_W{1'b1}}) begin
          w_state_next = S_IDLE;
          w_tmo_fire   = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // The commit slot's contents come from the live inputs or from the held load.
  always_comb begin
    w_src_rd       = r_rd;
    w_src_regwrite = r_regwrite;
    w_src_misalign = r_misalign;
    w_src_wdata    = load_extend(r_funct3, r_lane, mem_rdata_i);
    if (w_commit_new) begin
      w_src_rd       = rd_i;
      w_src_regwrite = regwrite_i;
      w_src_misalign = w_in_mem && is_misaligned(funct3_i, alu_i[1:0]);
      case (WBSel_i)
        WB_MEM:  w_src_wdata = load_extend(funct3_i, alu_i[1:0], mem_rdata_i);
        WB_PC4:  w_src_wdata = pc_i + XLEN'(4);
        default: w_src_wdata = alu_i;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo      <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_funct3   <= '0;
      r_lane     <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (r_state == S_WAIT && w_state_next == S_WAIT) r_tmo <= w_tmo_inc;
      else                                             r_tmo <= '0;
      if (w_accept) begin
        r_rd       <= rd_i;
        r_regwrite <= regwrite_i;
        r_funct3   <= funct3_i;
        r_lane     <= alu_i[1:0];
        r_misalign <= w_in_mem && is_misaligned(funct3_i, alu_i[1:0]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_load_err <= 1'b0;
      r_instret  <= '0;
    end else begin
      r_rf_we    <= 1'b0;
      r_load_err <= w_tmo_fire;
      if (w_commit) begin
        if (w_src_misalign) begin
          r_load_err <= 1'b1;
        end else begin
          r_instret <= r_instret + CNT_W'(1);
          if (w_src_regwrite && (w_src_rd != '0)) begin
            r_rf_we    <= 1'b1;
            r_rf_waddr <= w_src_rd;
            r_rf_wdata <= w_src_wdata;
          end
        end
      end
    end
  end

  assign rf_we_o     = r_rf_we;
  assign rf_waddr_o  = r_rf_waddr;
  assign rf_wdata_o  = r_rf_wdata;
  assign fwd_valid_o = r_rf_we;
  assign load_err_o  = r_load_err;
  assign instret_o   = r_instret;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage.
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic        flush_i;
  logic [4:0]  rd_i;
  logic        regwrite_i;
  logic [1:0]  WBSel_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_i;
  logic [31:0] pc_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        fwd_valid_o;
  logic        load_err_o;
  logic [63:0] instret_o;

  int n_total;
  int n_pass;

  writeback_stage #(.XLEN(32), .REG_AW(5), .CNT_W(64), .TMO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
    .rd_i(rd_i), .regwrite_i(regwrite_i), .WBSel_i(WBSel_i), .funct3_i(funct3_i),
    .alu_i(alu_i), .pc_i(pc_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .fwd_valid_o(fwd_valid_o), .load_err_o(load_err_o), .instret_o(instret_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single accept edge, then drop valid and rvalid.
  task automatic issue(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc,
                       input logic rv, input logic [31:0] rdata);
    rd_i = rd; regwrite_i = rw; WBSel_i = sel; funct3_i = f3;
    alu_i = alu; pc_i = pc; mem_rvalid_i = rv; mem_rdata_i = rdata;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  task automatic chk_write(input string tag, input logic [4:0] a, input logic [31:0] d,
                           input logic [63:0] cnt);
    chk({tag, "_we"}, rf_we_o, 1'b1);
    chk({tag, "_fwd"}, fwd_valid_o, 1'b1);
    chk({tag, "_waddr"}, rf_waddr_o, a);
    chk({tag, "_wdata"}, rf_wdata_o, d);
    chk({tag, "_instret"}, instret_o, cnt);
  endtask

  initial begin
    n_total = 0; n_pass = 0;
    rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; rd_i = '0; regwrite_i = 1'b0;
    WBSel_i = '0; funct3_i = '0; alu_i = '0; pc_i = '0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    #12;
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_we", rf_we_o, 1'b0);
    chk("rst_waddr", rf_waddr_o, 5'd0);
    chk("rst_wdata", rf_wdata_o, 32'd0);
    chk("rst_err", load_err_o, 1'b0);
    chk("rst_instret", instret_o, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    step();

    issue(5'd5, 1'b1, 2'b01, 3'b000, 32'h1234, 32'h0, 1'b0, 32'h0);
    chk_write("alu", 5'd5, 32'h1234, 64'd1);
    step();
    chk("alu_we_drop", rf_we_o, 1'b0);
    chk("alu_hold_addr", rf_waddr_o, 5'd5);
    chk("alu_hold_data", rf_wdata_o, 32'h1234);

    issue(5'd1, 1'b1, 2'b10, 3'b000, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    chk_write("pc4wrap", 5'd1, 32'h0, 64'd2);
    issue(5'd2, 1'b1, 2'b10, 3'b000, 32'h0, 32'h100, 1'b0, 32'h0);
    chk_write("pc4", 5'd2, 32'h104, 64'd3);

    issue(5'd6, 1'b1, 2'b00, 3'b000, 32'h1003, 32'h0, 1'b1, 32'h80FF_7F01);
    chk_write("lb", 5'd6, 32'hFFFF_FF80, 64'd4);
    issue(5'd6, 1'b1, 2'b00, 3'b100, 32'h1001, 32'h0, 1'b1, 32'h80FF_7F01);
    chk_write("lbu", 5'd6, 32'h0000_007F, 64'd5);
    issue(5'd6, 1'b1, 2'b00, 3'b001, 32'h1002, 32'h0, 1'b1, 32'h80FF_7F01);
    chk_write("lh", 5'd6, 32'hFFFF_80FF, 64'd6);

    issue(5'd7, 1'b1, 2'b00, 3'b010, 32'h1000, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("late_ready%0d", i), ready_o, 1'b0);
      chk($sformatf("late_we%0d", i), rf_we_o, 1'b0);
      if (i == 2) begin mem_rvalid_i = 1'b1; mem_rdata_i = 32'h80FF_7F01; end
      step();
    end
    mem_rvalid_i = 1'b0;
    chk_write("late_lw", 5'd7, 32'h80FF_7F01, 64'd7);

    issue(5'd8, 1'b1, 2'b00, 3'b010, 32'h1002, 32'h0, 1'b1, 32'h80FF_7F01);
    chk("mis_err", load_err_o, 1'b1);
    chk("mis_we", rf_we_o, 1'b0);
    chk("mis_instret", instret_o, 64'd7);
    step();
    chk("mis_err_pulse", load_err_o, 1'b0);

    issue(5'd0, 1'b1, 2'b01, 3'b000, 32'hDEAD, 32'h0, 1'b0, 32'h0);
    chk("rd0_we", rf_we_o, 1'b0);
    chk("rd0_instret", instret_o, 64'd8);
    chk("rd0_hold_addr", rf_waddr_o, 5'd7);

    issue(5'd9, 1'b1, 2'b00, 3'b001, 32'h1001, 32'h0, 1'b0, 32'h0);
    chk("mislh_drain_ready", ready_o, 1'b0);
    mem_rvalid_i = 1'b1;
    step();
    mem_rvalid_i = 1'b0;
    chk("mislh_err", load_err_o, 1'b1);
    chk("mislh_we", rf_we_o, 1'b0);
    chk("mislh_instret", instret_o, 64'd8);

    issue(5'd9, 1'b1, 2'b00, 3'b010, 32'h2000, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("tmo_ready%0d", i), ready_o, 1'b0);
      chk($sformatf("tmo_err%0d", i), load_err_o, 1'b0);
      step();
    end
    chk("tmo_err", load_err_o, 1'b1);
    chk("tmo_ready", ready_o, 1'b1);
    chk("tmo_we", rf_we_o, 1'b0);
    chk("tmo_instret", instret_o, 64'd8);
    step();
    chk("tmo_err_pulse", load_err_o, 1'b0);

    issue(5'd10, 1'b1, 2'b00, 3'b010, 32'h3000, 32'h0, 1'b0, 32'h0);
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_ready", ready_o, 1'b1);
    chk("flush_err", load_err_o, 1'b0);
    chk("flush_we", rf_we_o, 1'b0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_5555;
    step();
    mem_rvalid_i = 1'b0;
    chk("flush_late_rvalid_we", rf_we_o, 1'b0);
    chk("flush_late_rvalid_instret", instret_o, 64'd8);

    flush_i = 1'b1;
    issue(5'd11, 1'b1, 2'b01, 3'b000, 32'h77, 32'h0, 1'b0, 32'h0);
    flush_i = 1'b0;
    chk("flush_block_we", rf_we_o, 1'b0);
    chk("flush_block_instret", instret_o, 64'd8);

    rst_n = 1'b0; #2; rst_n = 1'b1;
    step();
    chk("rst2_instret", instret_o, 64'd0);
    regwrite_i = 1'b1; WBSel_i = 2'b01; valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_i = 5'(i + 1); alu_i = 32'h100 + 32'(i);
      step();
      chk($sformatf("b2b_ready%0d", i), ready_o, 1'b1);
      chk_write($sformatf("b2b%0d", i), 5'(i + 1), 32'h100 + 32'(i), 64'(i + 1));
    end
    valid_i = 1'b0;

    issue(5'd12, 1'b1, 2'b00, 3'b010, 32'h4000, 32'h0, 1'b0, 32'h0);
    step();
    chk("rstwait_pre_ready", ready_o, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rstwait_ready", ready_o, 1'b1);
    chk("rstwait_we", rf_we_o, 1'b0);
    chk("rstwait_waddr", rf_waddr_o, 5'd0);
    chk("rstwait_wdata", rf_wdata_o, 32'd0);
    chk("rstwait_err", load_err_o, 1'b0);
    chk("rstwait_instret", instret_o, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    mem_rvalid_i = 1'b1;
    step();
    mem_rvalid_i = 1'b0;
    chk("rstwait_no_write", rf_we_o, 1'b0);
    chk("rstwait_no_err", load_err_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
